rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writers.
  - Port A: in-order pipeline writeback from MEM/WB.
  - Port B: out-of-order completions, e.g. load returns or long-latency units.
- B requests are buffered in a small FIFO. A normally has priority; a starvation counter guarantees B progress.
- The registered write-port outputs also serve as the EX forwarding source.

---
 rtl/rf_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates the single register-file write port between the
// in-order MEM/WB writeback (A) and buffered out-of-order completions (B).
// A has priority; a starvation counter forces a B grant after STARVE_MAX
// consecutive blocked cycles of a non-empty FIFO head.
// Optional feature macro: RF_WB_ARBITER_SCOREBOARD_EN adds the q_rd/q_busy
// pending-destination query used by the issue stage.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [REG_AW-1:0]        a_rd,
  input  logic [DATA_W-1:0]        a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [REG_AW-1:0]        b_rd,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     b_ready,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     starve_grant
`ifdef RF_WB_ARBITER_SCOREBOARD_EN
  ,
  input  logic [REG_AW-1:0]        q_rd,
  output logic                     q_busy
`endif
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WCW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } b_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;

  b_entry_t       mem [DEPTH];
  b_entry_t       head;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  logic           fifo_empty;
  logic           b_hs;
  logic           push;
  logic           pop;
  logic           a_win;

  // Handshake, grant and ready decode
  assign fifo_empty   = (fifo_count == '0);
  assign a_ready      = (state == NORMAL);
  assign b_ready      = (fifo_count < CW'(DEPTH));
  assign starve_grant = (state == STARVE);
  assign b_hs         = b_valid && b_ready;
  assign push         = b_hs && (b_rd != '0);
  assign a_win        = (state == NORMAL) && a_valid;
  assign pop          = !fifo_empty && ((state == STARVE) || !a_valid);
  assign head         = mem[rd_ptr];

  // FSM state register and starvation counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state: count blocked head cycles, force one B grant at the limit
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      NORMAL: begin
        if (pop || fifo_empty) begin
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCW'(STARVE_MAX - 1)) begin
          state_nxt    = STARVE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      STARVE: begin
        state_nxt    = NORMAL;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: b_rd, data: b_data};
    end
  end

  // Registered write port, also the EX forwarding source
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (a_win) begin
      rf_we    <= (a_rd != '0);
      rf_waddr <= a_rd;
      rf_wdata <= a_data;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= head.rd;
      rf_wdata <= head.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef RF_WB_ARBITER_SCOREBOARD_EN
  logic [DEPTH-1:0] ent_vld;

  // Per-entry valid bits so the query ignores stale slots
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_vld <= '0;
    end else begin
      if (pop)  ent_vld[rd_ptr] <= 1'b0;
      if (push) ent_vld[wr_ptr] <= 1'b1;
    end
  end

  // Pending-destination query: any valid entry or an in-flight B handshake
  always_comb begin
    q_busy = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_vld[i] && (mem[i].rd == q_rd)) q_busy = 1'b1;
    end
    if (b_hs && (b_rd == q_rd)) q_busy = 1'b1;
    if (q_rd == '0) q_busy = 1'b0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed table-driven bench for rf_wb_arbiter (default parameters).
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [63:0] b_data;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [2:0]  fifo_count;
  logic        starve_grant;
`ifdef RF_WB_ARBITER_SCOREBOARD_EN
  logic [4:0]  q_rd;
  logic        q_busy;
`endif

  int checks;
  int failures;

  rf_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fifo_count   (fifo_count),
    .starve_grant (starve_grant)
`ifdef RF_WB_ARBITER_SCOREBOARD_EN
    ,
    .q_rd         (q_rd),
    .q_busy       (q_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [63:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_sg;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [2:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                              input logic bv, input logic [4:0] brd, input logic [63:0] bd,
                              input logic ear, input logic ebr, input logic esg,
                              input logic ewe, input logic [4:0] ewa, input logic [63:0] ewd,
                              input logic [2:0] ecnt);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
    v.e_ar = ear; v.e_br = ebr; v.e_sg = esg;
    v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: check ready/starve before the edge, write port after it
  task automatic apply(input string tag, input vec_t v);
    a_valid = v.av; a_rd = v.ard; a_data = v.ad;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
    #1;
    chk({tag, " a_ready"}, 64'(a_ready), 64'(v.e_ar));
    chk({tag, " b_ready"}, 64'(b_ready), 64'(v.e_br));
    chk({tag, " starve_grant"}, 64'(starve_grant), 64'(v.e_sg));
    @(posedge clk);
    #1;
    chk({tag, " rf_we"}, 64'(rf_we), 64'(v.e_we));
    chk({tag, " rf_waddr"}, 64'(rf_waddr), 64'(v.e_wa));
    chk({tag, " rf_wdata"}, rf_wdata, v.e_wd);
    chk({tag, " fifo_count"}, 64'(fifo_count), 64'(v.e_cnt));
  endtask

  vec_t tbl [23];

  initial begin
    checks   = 0;
    failures = 0;
`ifdef RF_WB_ARBITER_SCOREBOARD_EN
    q_rd = 5'd0;
`endif

    // av ard ad | bv brd bd | a_ready b_ready starve | rf_we waddr wdata count
    tbl[0]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 0, 5'd0,  64'h0,    3'd0);
    tbl[1]  = mk(1, 5'd5,  64'h1234, 0, 5'd0, 64'h0,  1, 1, 0, 1, 5'd5,  64'h1234, 3'd0);
    tbl[2]  = mk(1, 5'd0,  64'h99,   0, 5'd0, 64'h0,  1, 1, 0, 0, 5'd0,  64'h99,   3'd0);
    tbl[3]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 0, 5'd0,  64'h99,   3'd0);
    tbl[4]  = mk(0, 5'd0,  64'h0,    1, 5'd3, 64'h55, 1, 1, 0, 0, 5'd0,  64'h99,   3'd1);
    tbl[5]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 1, 5'd3,  64'h55,   3'd0);
    tbl[6]  = mk(0, 5'd0,  64'h0,    1, 5'd0, 64'h77, 1, 1, 0, 0, 5'd3,  64'h55,   3'd0);
    tbl[7]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 0, 5'd3,  64'h55,   3'd0);
    tbl[8]  = mk(1, 5'd20, 64'hA0,   1, 5'd1, 64'hB1, 1, 1, 0, 1, 5'd20, 64'hA0,   3'd1);
    tbl[9]  = mk(1, 5'd21, 64'hA1,   1, 5'd2, 64'hB2, 1, 1, 0, 1, 5'd21, 64'hA1,   3'd2);
    tbl[10] = mk(1, 5'd22, 64'hA2,   1, 5'd3, 64'hB3, 1, 1, 0, 1, 5'd22, 64'hA2,   3'd3);
    tbl[11] = mk(1, 5'd23, 64'hA3,   1, 5'd4, 64'hB4, 1, 1, 0, 1, 5'd23, 64'hA3,   3'd4);
    tbl[12] = mk(1, 5'd24, 64'hA4,   1, 5'd5, 64'hB5, 1, 0, 0, 1, 5'd24, 64'hA4,   3'd4);
    tbl[13] = mk(1, 5'd25, 64'hA5,   0, 5'd0, 64'h0,  1, 0, 0, 1, 5'd25, 64'hA5,   3'd4);
    tbl[14] = mk(1, 5'd26, 64'hA6,   0, 5'd0, 64'h0,  1, 0, 0, 1, 5'd26, 64'hA6,   3'd4);
    tbl[15] = mk(1, 5'd27, 64'hA7,   0, 5'd0, 64'h0,  1, 0, 0, 1, 5'd27, 64'hA7,   3'd4);
    tbl[16] = mk(1, 5'd28, 64'hA8,   0, 5'd0, 64'h0,  1, 0, 0, 1, 5'd28, 64'hA8,   3'd4);
    tbl[17] = mk(1, 5'd29, 64'hA9,   0, 5'd0, 64'h0,  0, 0, 1, 1, 5'd1,  64'hB1,   3'd3);
    tbl[18] = mk(1, 5'd29, 64'hA9,   0, 5'd0, 64'h0,  1, 1, 0, 1, 5'd29, 64'hA9,   3'd3);
    tbl[19] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 1, 5'd2,  64'hB2,   3'd2);
    tbl[20] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 1, 5'd3,  64'hB3,   3'd1);
    tbl[21] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 1, 5'd4,  64'hB4,   3'd0);
    tbl[22] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 0, 5'd4,  64'hB4,   3'd0);

    // Reset held two cycles with both requesters active
    reset = 1'b0;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 64'h2;
    @(posedge clk);
    #1;
    chk("rst1 rf_we", 64'(rf_we), 64'd0);
    chk("rst1 fifo_count", 64'(fifo_count), 64'd0);
    @(posedge clk);
    #1;
    chk("rst2 rf_we", 64'(rf_we), 64'd0);
    chk("rst2 rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst2 rf_wdata", rf_wdata, 64'd0);
    chk("rst2 fifo_count", 64'(fifo_count), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Starvation: one B entry behind continuous A traffic
    for (int c = 0; c <= 10; c++) begin
      vec_t v;
      if (c == 0)
        v = mk(1, 5'd8, 64'h100, 1, 5'd7, 64'hAA, 1, 1, 0, 1, 5'd8, 64'h100, 3'd1);
      else if (c < 9)
        v = mk(1, 5'd8, 64'h100 + 64'(c), 0, 5'd0, 64'h0, 1, 1, 0, 1, 5'd8, 64'h100 + 64'(c), 3'd1);
      else if (c == 9)
        v = mk(1, 5'd8, 64'h109, 0, 5'd0, 64'h0, 0, 1, 1, 1, 5'd7, 64'hAA, 3'd0);
      else
        v = mk(1, 5'd8, 64'h10A, 0, 5'd0, 64'h0, 1, 1, 0, 1, 5'd8, 64'h10A, 3'd0);
      apply($sformatf("starve%0d", c), v);
    end

    // Simultaneous push/pop streaming through the pointer wrap
    apply("wrap0", mk(0, 5'd0, 64'h0, 1, 5'd10, 64'hC0, 1, 1, 0, 0, 5'd8, 64'h10A, 3'd1));
    for (int k = 1; k <= 5; k++) begin
      apply($sformatf("wrap%0d", k),
            mk(0, 5'd0, 64'h0, 1, 5'(10 + k), 64'hC0 + 64'(k),
               1, 1, 0, 1, 5'(10 + k - 1), 64'hC0 + 64'(k - 1), 3'd1));
    end
    apply("wrap6", mk(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 1, 0, 1, 5'd15, 64'hC5, 3'd0));
    apply("wrap7", mk(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 1, 0, 0, 5'd15, 64'hC5, 3'd0));

`ifdef RF_WB_ARBITER_SCOREBOARD_EN
    // Pending-destination query across enqueue, pop and retire
    q_rd = 5'd9;
    a_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h9;
    #1;
    chk("sb handshake q_busy", 64'(q_busy), 64'd1);
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_rd = 5'd0;
    #1;
    chk("sb pending q_busy", 64'(q_busy), 64'd1);
    @(posedge clk);
    #1;
    chk("sb retire rf_we", 64'(rf_we), 64'd1);
    chk("sb retire rf_waddr", 64'(rf_waddr), 64'd9);
    chk("sb retired q_busy", 64'(q_busy), 64'd0);
    q_rd = 5'd0;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 64'h1;
    #1;
    chk("sb zero q_busy", 64'(q_busy), 64'd0);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    chk("sb zero fifo_count", 64'(fifo_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
